// File: rtl/pr_free_list.sv
// pr_free_list: circular free list of physical registers for the rename stage.
// Hands out up to 4 PRs per cycle in lane order, reclaims up to 4 retired PRs
// per cycle, and on a stage-4 flush rewinds the speculative head to the
// committed head so every speculatively allocated PR returns to the list.
// Optional consistency checker (sticky fl_err) is built when FREE_LIST_CHECK_EN
// is defined; otherwise fl_err is tied low and no checking logic exists.
//
// Handshake: alloc_req is a per-lane request held by rename; alloc_ok and
// alloc_pr0..3 are combinational from registered state. A grant happens only on
// a clock edge where alloc_ok=1 (all-or-nothing); otherwise rename stalls and
// keeps its request. Retire frees have no back-pressure and apply every edge.
module pr_free_list #(
    parameter int PR_NUM = 64,
    parameter int AR_NUM = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_stage4,
    input  logic [3:0] alloc_req,
    output logic       alloc_ok,
    output logic [5:0] alloc_pr0,
    output logic [5:0] alloc_pr1,
    output logic [5:0] alloc_pr2,
    output logic [5:0] alloc_pr3,
    input  logic [3:0] retire_en,
    input  logic [5:0] retire_old_pr0,
    input  logic [5:0] retire_old_pr1,
    input  logic [5:0] retire_old_pr2,
    input  logic [5:0] retire_old_pr3,
    output logic [6:0] free_count,
    output logic       fl_err
);
    localparam int PR_W  = $clog2(PR_NUM);
    localparam int PTR_W = PR_W + 1;

    typedef logic [PR_W-1:0]  pr_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [2:0]       cnt_t;

    pr_t  fl_q [PR_NUM];
    pr_t  fl_d [PR_NUM];
    ptr_t head_q, head_d;
    ptr_t c_head_q, c_head_d;
    ptr_t tail_q, tail_d;

    pr_t  ret_pr [4];
    pr_t  alloc_pr [4];
    cnt_t a_off [4];
    cnt_t r_off [4];
    pr_t  a_idx [4];
    pr_t  r_idx [4];
    cnt_t n_req;
    cnt_t m_ret;

    assign ret_pr[0] = retire_old_pr0;
    assign ret_pr[1] = retire_old_pr1;
    assign ret_pr[2] = retire_old_pr2;
    assign ret_pr[3] = retire_old_pr3;

    assign alloc_pr0 = alloc_pr[0];
    assign alloc_pr1 = alloc_pr[1];
    assign alloc_pr2 = alloc_pr[2];
    assign alloc_pr3 = alloc_pr[3];

    // Prefix counts give each active lane its slot offset; totals are the popcounts.
    always_comb begin
        n_req = '0;
        m_ret = '0;
        for (int k = 0; k < 4; k++) begin
            a_off[k] = n_req;
            r_off[k] = m_ret;
            a_idx[k] = head_q[PR_W-1:0] + pr_t'(n_req);
            r_idx[k] = tail_q[PR_W-1:0] + pr_t'(m_ret);
            n_req    = n_req + {2'b00, alloc_req[k]};
            m_ret    = m_ret + {2'b00, retire_en[k]};
        end
    end

    assign free_count = tail_q - head_q;
    assign alloc_ok   = (ptr_t'(n_req) <= free_count) && !flush_stage4;

    // Grant lookup: requesting lanes read consecutive entries from head, others drive 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            alloc_pr[k] = alloc_req[k] ? fl_q[a_idx[k]] : '0;
        end
    end

    // Next state: compact frees at tail, advance committed head, then alloc or flush rewind.
    always_comb begin
        fl_d = fl_q;
        for (int k = 0; k < 4; k++) begin
            if (retire_en[k]) begin
                fl_d[r_idx[k]] = ret_pr[k];
            end
        end
        tail_d   = tail_q + ptr_t'(m_ret);
        c_head_d = c_head_q + ptr_t'(m_ret);
        if (flush_stage4) begin
            head_d = c_head_d;
        end else if (alloc_ok) begin
            head_d = head_q + ptr_t'(n_req);
        end else begin
            head_d = head_q;
        end
    end

    // State registers; reset loads the unmapped PRs AR_NUM..PR_NUM-1 as free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PR_NUM; i++) begin
                fl_q[i] <= (i < PR_NUM - AR_NUM) ? pr_t'(i + AR_NUM) : '0;
            end
            head_q   <= '0;
            c_head_q <= '0;
            tail_q   <= ptr_t'(PR_NUM - AR_NUM);
        end else begin
            fl_q     <= fl_d;
            head_q   <= head_d;
            c_head_q <= c_head_d;
            tail_q   <= tail_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic fl_err_q, fl_err_d;
    pr_t  reg_off [PR_NUM];
    ptr_t head_alloc;
    logic ovf_hit, pass_hit, dup_hit;

    // Distance of each slot from head; slots closer than free_count are free.
    always_comb begin
        for (int i = 0; i < PR_NUM; i++) begin
            reg_off[i] = pr_t'(i) - head_q[PR_W-1:0];
        end
    end

    // Overflow, committed-head overrun and double-free detection, folded into a sticky flag.
    always_comb begin
        ovf_hit    = ({1'b0, free_count} + (PTR_W+1)'(m_ret)) > (PTR_W+1)'(PR_NUM);
        head_alloc = alloc_ok ? head_q + ptr_t'(n_req) : head_q;
        pass_hit   = !flush_stage4 && (ptr_t'(m_ret) > ptr_t'(head_alloc - c_head_q));
        dup_hit    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < PR_NUM; i++) begin
                if (retire_en[k] && (fl_q[i] == ret_pr[k]) &&
                    ({1'b0, reg_off[i]} < free_count)) begin
                    dup_hit = 1'b1;
                end
            end
        end
        fl_err_d = fl_err_q | ovf_hit | pass_hit | dup_hit;
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fl_err_q <= 1'b0;
        end else begin
            fl_err_q <= fl_err_d;
        end
    end

    assign fl_err = fl_err_q;
`else
    assign fl_err = 1'b0;
`endif

endmodule
